// File: rtl/fdc_sync.sv
// fdc_sync: frequency-to-digital converter that counts FPTAT rising edges inside
// a window of win_len FREF rising edges. Both inputs are asynchronous to clk.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start             single-cycle request for one measurement (ignored while busy)
//   cont              continuous mode: re-arm after every completed window
//   win_len[REF_W]    window length in FREF rising edges (0 treated as 1)
//   FREF, FPTAT       asynchronous reference / measured frequencies
//   data[PTAT_W]      FPTAT edge count of the last completed window
//   overflow          last completed window saturated the counter
//   data_valid        one-cycle pulse when data/overflow update
//   busy              high while a measurement is armed, counting or finishing
`timescale 1ns/1ps

module fdc_sync #(
    parameter int unsigned REF_W       = 4,
    parameter int unsigned PTAT_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cont,
    input  logic [REF_W-1:0]  win_len,
    input  logic              FREF,
    input  logic              FPTAT,
    output logic [PTAT_W-1:0] data,
    output logic              overflow,
    output logic              data_valid,
    output logic              busy
);

    localparam logic [PTAT_W-1:0] PTAT_MAX = {PTAT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Synchroniser chains plus one edge-detect flop per input
    logic [SYNC_STAGES-1:0] ref_sync_q;
    logic [SYNC_STAGES-1:0] ptat_sync_q;
    logic                   ref_dly_q;
    logic                   ptat_dly_q;
    logic                   ref_rise_c;
    logic                   ptat_rise_c;

    state_t              state_q, state_d;
    logic [PTAT_W-1:0]   ptat_cnt_q, ptat_cnt_d;
    logic [REF_W-1:0]    ref_cnt_q, ref_cnt_d;
    logic [REF_W-1:0]    win_q, win_d;
    logic                sat_q, sat_d;
    logic [PTAT_W-1:0]   data_d;
    logic                overflow_d;
    logic                data_valid_d;
    logic                busy_d;

    // Synchronise the two asynchronous frequencies into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_sync_q  <= '0;
            ptat_sync_q <= '0;
            ref_dly_q   <= 1'b0;
            ptat_dly_q  <= 1'b0;
        end else begin
            ref_sync_q  <= {ref_sync_q[SYNC_STAGES-2:0], FREF};
            ptat_sync_q <= {ptat_sync_q[SYNC_STAGES-2:0], FPTAT};
            ref_dly_q   <= ref_sync_q[SYNC_STAGES-1];
            ptat_dly_q  <= ptat_sync_q[SYNC_STAGES-1];
        end
    end

    // Single-cycle rising-edge pulses
    assign ref_rise_c  = ref_sync_q[SYNC_STAGES-1]  & ~ref_dly_q;
    assign ptat_rise_c = ptat_sync_q[SYNC_STAGES-1] & ~ptat_dly_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptat_cnt_q <= '0;
            ref_cnt_q  <= '0;
            win_q      <= REF_W'(1);
            sat_q      <= 1'b0;
            data       <= '0;
            overflow   <= 1'b0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptat_cnt_q <= ptat_cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            win_q      <= win_d;
            sat_q      <= sat_d;
            data       <= data_d;
            overflow   <= overflow_d;
            data_valid <= data_valid_d;
            busy       <= busy_d;
        end
    end

    // Next-state and next-output logic. Results are loaded on the closing edge
    // so data, overflow and data_valid all change together while in DONE.
    always_comb begin
        state_d      = state_q;
        ptat_cnt_d   = ptat_cnt_q;
        ref_cnt_d    = ref_cnt_q;
        win_d        = win_q;
        sat_d        = sat_q;
        data_d       = data;
        overflow_d   = overflow;
        data_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start || cont) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (ref_rise_c) begin
                    ptat_cnt_d = '0;
                    ref_cnt_d  = '0;
                    sat_d      = 1'b0;
                    win_d      = (win_len == '0) ? REF_W'(1) : win_len;
                    state_d    = COUNT;
                end
            end
            COUNT: begin
                if (ptat_rise_c) begin
                    if (ptat_cnt_q == PTAT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        ptat_cnt_d = ptat_cnt_q + PTAT_W'(1);
                    end
                end
                if (ref_rise_c) begin
                    ref_cnt_d = ref_cnt_q + REF_W'(1);
                    // A coincident ptat_rise is already folded into ptat_cnt_d
                    if (ref_cnt_q == win_q - REF_W'(1)) begin
                        state_d      = DONE;
                        data_d       = ptat_cnt_d;
                        overflow_d   = sat_d;
                        data_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = cont ? ARM : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule
